grf_wr_arbiter: RTL

//   Shares the single GRF write port between two requesters:
//   - W-stage writeback: fixed priority, no backpressure.
//   - Multi-cycle mult/div unit (MDU): valid/ready handshake.

---
 rtl/grf_wr_arbiter_if.sv | 32 +++
 rtl/grf_wr_arbiter.sv | 98 +++++++++
 2 files changed

// File: rtl/grf_wr_arbiter_if.sv
// GRF write-port bundle: W-stage writeback, MDU handshake and registered GRF write.
// The master drives the requests; the arbiter sits on the slave side.
interface grf_wr_arbiter_if;
    logic        wb_valid;
    logic [4:0]  wb_a3;
    logic [31:0] wb_wd;
    logic [31:0] wb_pc;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_a3;
    logic [31:0] md_wd;
    logic [31:0] md_pc;
    logic        stall_req;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic [31:0] rf_pc;

    modport master (
        output wb_valid, wb_a3, wb_wd, wb_pc,
        output md_valid, md_a3, md_wd, md_pc,
        input  md_ready, stall_req,
        input  rf_we, rf_a3, rf_wd, rf_pc
    );

    modport slave (
        input  wb_valid, wb_a3, wb_wd, wb_pc,
        input  md_valid, md_a3, md_wd, md_pc,
        output md_ready, stall_req,
        output rf_we, rf_a3, rf_wd, rf_pc
    );
endinterface

// File: rtl/grf_wr_arbiter.sv
// Shares the GRF write port between W-stage writeback (priority) and the MDU,
// registering the winner onto the GRF and requesting a bubble when the MDU starves.
module grf_wr_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    grf_wr_arbiter_if.slave   bus
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] FORCE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [4:0]    a3_q, a3_d;
    logic [31:0]   wd_q, wd_d;
    logic [31:0]   pc_q, pc_d;

    logic          wb_req;
    logic          md_rdy;
    logic          md_hs;
    logic          limit_hit;
    logic [CW-1:0] cnt_inc;

    // A writeback to $0 is not a request, so it leaves the port to the MDU.
    always_comb begin
        wb_req    = bus.wb_valid && (bus.wb_a3 != 5'd0);
        md_rdy    = !rst && bus.md_valid && !wb_req;
        md_hs     = bus.md_valid && md_rdy;
        cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        limit_hit = (int'(cnt_q) + 1) >= MAX_WAIT;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (rst) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (!bus.md_valid || md_hs) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_inc;
            unique case (state_q)
                IDLE, WAIT: state_d = limit_hit ? FORCE : WAIT;
                FORCE:      state_d = FORCE;
                default:    state_d = IDLE;
            endcase
        end
    end

    // Fields track the winner; an MDU write to $0 still wins but keeps rf_we low.
    always_comb begin
        we_d = 1'b0;
        a3_d = a3_q;
        wd_d = wd_q;
        pc_d = pc_q;
        if (rst) begin
            a3_d = '0;
            wd_d = '0;
            pc_d = '0;
        end else if (wb_req) begin
            we_d = 1'b1;
            a3_d = bus.wb_a3;
            wd_d = bus.wb_wd;
            pc_d = bus.wb_pc;
        end else if (md_hs) begin
            we_d = (bus.md_a3 != 5'd0);
            a3_d = bus.md_a3;
            wd_d = bus.md_wd;
            pc_d = bus.md_pc;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        we_q    <= we_d;
        a3_q    <= a3_d;
        wd_q    <= wd_d;
        pc_q    <= pc_d;
    end

    assign bus.md_ready  = md_rdy;
    assign bus.stall_req = (state_q == FORCE);
    assign bus.rf_we     = we_q;
    assign bus.rf_a3     = a3_q;
    assign bus.rf_wd     = wd_q;
    assign bus.rf_pc     = pc_q;

endmodule
